// File: rtl/ctrl_encode_def.sv
// rtl/ctrl_encode_def.sv - shared encodings for branch outcome, next-PC select and hazard FSM state
package ctrl_encode_def;

  typedef enum logic [1:0] {
    NT_PCPLUS4     = 2'b00,
    NT_BRANCH      = 2'b01,
    NT_BRANCHWRONG = 2'b10,
    NT_JUMP        = 2'b11
  } nexttype_e;

  localparam logic [1:0] PCSRC_PC4     = 2'b00;
  localparam logic [1:0] PCSRC_JUMP    = 2'b01;
  localparam logic [1:0] PCSRC_IDEXPC4 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LSTALL = 2'b01,
    S_MDBUSY = 2'b10
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: redirect flushes, load-use stalls, mul/div occupancy
module hazard_ctrl
  import ctrl_encode_def::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        nexttype,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_use_rt,
  input  logic              md_start,
  input  logic              clr_stats,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int CW = $clog2(max_int(LOAD_LAT, MD_LAT) + 1);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load_haz;
  logic          redirect;

  // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_haz = idex_memread && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));
  assign redirect = (nexttype == NT_BRANCHWRONG) || (nexttype == NT_JUMP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_write    = 1'b1;
    pc_src      = PCSRC_PC4;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rstn) begin
      case (state)
        S_IDLE: begin
          if (redirect) begin
            pc_src     = (nexttype == NT_JUMP) ? PCSRC_JUMP : PCSRC_IDEXPC4;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_haz) begin
            // A coincident md_start is dropped here; EX re-presents it once the load clears.
            pc_write   = 1'b0;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = S_LSTALL;
              cnt_nxt   = CW'(LOAD_LAT - 1);
            end
          end else if (md_start) begin
            state_nxt = S_MDBUSY;
            cnt_nxt   = CW'(MD_LAT - 1);
          end
        end
        S_LSTALL: begin
          pc_write   = 1'b0;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          cnt_nxt    = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = S_IDLE;
        end
        S_MDBUSY: begin
          pc_write    = 1'b0;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_flush = 1'b1;
          cnt_nxt     = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr_stats),
    .inc  (!pc_write),
    .cnt  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr_stats),
    .inc  (ifid_flush),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector and sequence bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 2;
  localparam int MD_LAT   = 4;
  localparam int CNT_W    = 4;

  localparam logic [7:0] O_DEF  = 8'h80;
  localparam logic [7:0] O_LD   = 8'h12;
  localparam logic [7:0] O_BW   = 8'hCA;
  localparam logic [7:0] O_JMP  = 8'hAA;
  localparam logic [7:0] O_MD   = 8'h15;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [1:0]        nexttype = 2'b00;
  logic              idex_memread = 1'b0;
  logic [REG_AW-1:0] idex_rt = '0;
  logic [REG_AW-1:0] ifid_rs = '0;
  logic [REG_AW-1:0] ifid_rt = '0;
  logic              ifid_use_rt = 1'b0;
  logic              md_start = 1'b0;
  logic              clr_stats = 1'b0;
  logic              pc_write;
  logic [1:0]        pc_src;
  logic              ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush;
  logic              busy;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic [7:0]        outs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .MD_LAT(MD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .nexttype(nexttype), .idex_memread(idex_memread),
    .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
    .md_start(md_start), .clr_stats(clr_stats), .pc_write(pc_write), .pc_src(pc_src),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_stall(idex_stall),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {pc_write, pc_src, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush};

  typedef struct {
    logic [1:0] nt;
    logic       mr;
    logic [4:0] xrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       md;
    logic [7:0] exp_outs;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    nexttype = 2'b00; idex_memread = 1'b0; idex_rt = '0; ifid_rs = '0;
    ifid_rt = '0; ifid_use_rt = 1'b0; md_start = 1'b0; clr_stats = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic set_haz(input logic [1:0] nt);
    nexttype = nt; idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
  endtask

  function automatic vec_t mk(input logic [1:0] nt, input logic mr, input logic [4:0] xrt,
                              input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                              input logic md, input logic [7:0] eo, input logic eb);
    vec_t v;
    v.nt = nt; v.mr = mr; v.xrt = xrt; v.rs = rs; v.rt = rt; v.use_rt = use_rt;
    v.md = md; v.exp_outs = eo; v.exp_busy = eb;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_DEF, 1'b0);
    vecs[1]  = mk(2'b00, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, O_LD,  1'b1);
    vecs[2]  = mk(2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, O_DEF, 1'b0);
    vecs[3]  = mk(2'b00, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, O_DEF, 1'b0);
    vecs[4]  = mk(2'b00, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, O_LD,  1'b1);
    vecs[5]  = mk(2'b00, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, O_DEF, 1'b0);
    vecs[6]  = mk(2'b10, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, O_BW,  1'b0);
    vecs[7]  = mk(2'b11, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, O_JMP, 1'b0);
    vecs[8]  = mk(2'b01, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, O_LD,  1'b1);
    vecs[9]  = mk(2'b01, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, O_DEF, 1'b1);
    vecs[10] = mk(2'b00, 1'b1, 5'd4, 5'd1, 5'd4, 1'b1, 1'b1, O_LD,  1'b1);

    // Reset state
    idle_inputs();
    set_haz(2'b00);
    #2;
    chk("rst_outs_forced", {8'h0, outs}, {8'h0, O_DEF});
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_stall_cnt", {12'h0, stall_cnt}, 16'h0);
    chk("rst_flush_cnt", {12'h0, flush_cnt}, 16'h0);
    idle_inputs();

    // Single-cycle IDLE decode vectors, each from a fresh reset
    for (int i = 0; i < 11; i++) begin
      do_reset();
      @(negedge clk);
      nexttype = vecs[i].nt; idex_memread = vecs[i].mr; idex_rt = vecs[i].xrt;
      ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt; ifid_use_rt = vecs[i].use_rt;
      md_start = vecs[i].md;
      #2;
      chk($sformatf("vec%0d_outs", i), {8'h0, outs}, {8'h0, vecs[i].exp_outs});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy_next", i), {15'h0, busy}, {15'h0, vecs[i].exp_busy});
    end

    // Load-use stall lasts LOAD_LAT cycles
    do_reset();
    @(negedge clk);
    set_haz(2'b00);
    #1;
    chk("ld_cyc1", {8'h0, outs}, {8'h0, O_LD});
    @(posedge clk);
    #1;
    chk("ld_cyc2", {8'h0, outs}, {8'h0, O_LD});
    chk("ld_cyc2_busy", {15'h0, busy}, 16'h1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("ld_after", {8'h0, outs}, {8'h0, O_DEF});
    chk("ld_after_busy", {15'h0, busy}, 16'h0);
    chk("ld_stall_cnt", {12'h0, stall_cnt}, 16'd2);

    // Redirect beats a simultaneous load hazard
    do_reset();
    @(negedge clk);
    set_haz(2'b10);
    #1;
    chk("bw_outs", {8'h0, outs}, {8'h0, O_BW});
    @(negedge clk);
    idle_inputs();
    #1;
    chk("bw_after", {8'h0, outs}, {8'h0, O_DEF});
    chk("bw_busy", {15'h0, busy}, 16'h0);
    chk("bw_flush_cnt", {12'h0, flush_cnt}, 16'd1);
    chk("bw_stall_cnt", {12'h0, stall_cnt}, 16'd0);

    // Mul/div occupancy with a Jump ignored while busy
    do_reset();
    @(negedge clk);
    md_start = 1'b1;
    #1;
    chk("md_start_outs", {8'h0, outs}, {8'h0, O_DEF});
    @(negedge clk);
    md_start = 1'b0;
    nexttype = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("md_busy%0d_outs", c), {8'h0, outs}, {8'h0, O_MD});
      chk($sformatf("md_busy%0d_busy", c), {15'h0, busy}, 16'h1);
      @(negedge clk);
    end
    nexttype = 2'b00;
    #1;
    chk("md_done_outs", {8'h0, outs}, {8'h0, O_DEF});
    chk("md_done_busy", {15'h0, busy}, 16'h0);
    chk("md_stall_cnt", {12'h0, stall_cnt}, 16'd3);
    chk("md_flush_cnt", {12'h0, flush_cnt}, 16'd0);

    // Asynchronous reset in MDBUSY cycle 2
    do_reset();
    @(negedge clk);
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("mdrst_outs", {8'h0, outs}, {8'h0, O_DEF});
    chk("mdrst_busy", {15'h0, busy}, 16'h0);
    chk("mdrst_stall_cnt", {12'h0, stall_cnt}, 16'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("mdrst_release_outs", {8'h0, outs}, {8'h0, O_DEF});
    chk("mdrst_release_busy", {15'h0, busy}, 16'h0);

    // Saturation after 20 stall cycles, then clear beats an increment
    do_reset();
    @(negedge clk);
    set_haz(2'b00);
    for (int c = 0; c < 20; c++) @(posedge clk);
    #1;
    chk("sat_stall_cnt", {12'h0, stall_cnt}, 16'd15);
    @(negedge clk);
    clr_stats = 1'b1;
    #1;
    chk("clr_pc_write_low", {15'h0, pc_write}, 16'h0);
    @(posedge clk);
    #1;
    chk("clr_stall_cnt", {12'h0, stall_cnt}, 16'd0);
    chk("clr_flush_cnt", {12'h0, flush_cnt}, 16'd0);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
